tile_buffer: RTL and testbench

- On-chip colour store for one 32x32 tile, sitting downstream of the tile rasterizer.
- Accepts one pixel write per cycle on the rasterizer's pixel interface (X, Y, clearPixel, rasterPixel).
- On a flush request, streams the 1024 stored pixels in raster order over a valid/ready interface to the framebuffer writer.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/tile_ram.sv | 31 +++
 rtl/tile_buffer.sv | 144 ++++++++++++++
 tb/tb_tile_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU tile constants and types used by the tile buffer and its bench.
package gpu_pkg;

    localparam int COLOR_W     = 16;
    localparam int TILE_LOG2   = 5;
    localparam int TILE_PIXELS = 1 << (2 * TILE_LOG2);

    typedef logic [COLOR_W-1:0]     color_t;
    typedef logic [2*TILE_LOG2-1:0] tile_addr_t;   // {Y, X}

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } tile_state_e;

    function automatic tile_addr_t pix_addr(input logic [TILE_LOG2-1:0] x,
                                            input logic [TILE_LOG2-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with
// read enable and 1-cycle latency; read data holds while re is low.
module tile_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // NOTE: the array and read register carry no reset so the tools can map them onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tile_buffer.sv
// 32x32 tile colour store: pixel writes from the rasterizer, raster-order
// valid/ready flush stream. Optional raster_count port via TILE_BUFFER_STATS_EN.
module tile_buffer #(
    parameter int COLOR_W   = gpu_pkg::COLOR_W,
    parameter int TILE_LOG2 = gpu_pkg::TILE_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TILE_LOG2-1:0]   X,
    input  logic [TILE_LOG2-1:0]   Y,
    input  logic                   clearPixel,
    input  logic                   rasterPixel,
    input  logic [COLOR_W-1:0]     tri_color,
    input  logic [COLOR_W-1:0]     clear_color,
    input  logic                   flush,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLOR_W-1:0]     out_data,
    output logic [TILE_LOG2-1:0]   out_x,
    output logic [TILE_LOG2-1:0]   out_y,
    output logic                   out_last,
    output logic                   wr_drop
`ifdef TILE_BUFFER_STATS_EN
    ,
    output logic [2*TILE_LOG2:0]   raster_count
`endif
);

    localparam int ADDR_W = 2 * TILE_LOG2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    gpu_pkg::tile_state_e state_q, state_d;

    // One spare MSB marks "every address already fetched".
    logic [ADDR_W:0]   rd_addr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              wr_drop_q;

    logic               pix_req;
    logic               wr_en;
    logic [COLOR_W-1:0] wr_data;
    logic               rd_en;
    logic [COLOR_W-1:0] rd_data;
    logic               flush_start;
    logic               beat_accept;
    logic               last_accept;

    assign pix_req     = rasterPixel | clearPixel;
    assign wr_en       = (state_q == gpu_pkg::ST_IDLE) & pix_req;
    assign wr_data     = rasterPixel ? tri_color : clear_color;
    assign flush_start = (state_q == gpu_pkg::ST_IDLE) & flush;
    assign rd_en       = (state_q == gpu_pkg::ST_FLUSH) & (~out_valid_q | out_ready)
                       & ~rd_addr_q[ADDR_W];
    assign beat_accept = out_valid_q & out_ready;
    assign last_accept = beat_accept & out_last_q;

    // NOTE: every clocked process uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= gpu_pkg::ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            gpu_pkg::ST_IDLE:  if (flush)       state_d = gpu_pkg::ST_FLUSH;
            gpu_pkg::ST_FLUSH: if (last_accept) state_d = gpu_pkg::ST_IDLE;
            default:                            state_d = gpu_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q   <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            wr_drop_q <= (state_q == gpu_pkg::ST_FLUSH) & pix_req;
            if (flush_start) begin
                rd_addr_q <= '0;
            end
            // A fetch refills the output slot; otherwise an accepted beat empties it.
            if (rd_en) begin
                rd_addr_q   <= rd_addr_q + (ADDR_W + 1)'(1);
                out_valid_q <= 1'b1;
                out_addr_q  <= rd_addr_q[ADDR_W-1:0];
                out_last_q  <= (rd_addr_q == {1'b0, LAST_ADDR});
            end else if (beat_accept) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    tile_ram #(
        .DATA_W (COLOR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({Y, X}),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    // RAM read data is not reset, so it is masked to zero whenever no beat is offered.
    assign busy      = (state_q == gpu_pkg::ST_FLUSH);
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? rd_data : '0;
    assign out_x     = out_addr_q[TILE_LOG2-1:0];
    assign out_y     = out_addr_q[ADDR_W-1:TILE_LOG2];
    assign out_last  = out_last_q;
    assign wr_drop   = wr_drop_q;

`ifdef TILE_BUFFER_STATS_EN
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] raster_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raster_cnt_q <= '0;
        end else if (flush_start) begin
            raster_cnt_q <= '0;
        end else if (wr_en && rasterPixel && raster_cnt_q != CNT_MAX) begin
            raster_cnt_q <= raster_cnt_q + (ADDR_W + 1)'(1);
        end
    end

    assign raster_count = raster_cnt_q;
`endif

endmodule

// File: tb/tb_tile_buffer.sv
// Self-checking bench for tile_buffer: table-driven pixel writes plus
// directed flush sequences (backpressure, dropped writes, re-flush, reset).
module tb_tile_buffer;
    import gpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] X, Y;
    logic       clearPixel, rasterPixel, flush, out_ready;
    color_t     tri_color, clear_color;
    logic       busy, out_valid, out_last, wr_drop;
    color_t     out_data;
    logic [4:0] out_x, out_y;
`ifdef TILE_BUFFER_STATS_EN
    logic [10:0] raster_count;
`endif

    tile_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .X           (X),
        .Y           (Y),
        .clearPixel  (clearPixel),
        .rasterPixel (rasterPixel),
        .tri_color   (tri_color),
        .clear_color (clear_color),
        .flush       (flush),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_last    (out_last),
        .wr_drop     (wr_drop)
`ifdef TILE_BUFFER_STATS_EN
        ,
        .raster_count(raster_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    color_t model [TILE_PIXELS];
    color_t cap   [TILE_PIXELS];

    typedef struct {
        logic [4:0] x;
        logic [4:0] y;
        logic       r;
        logic       c;
        color_t     tri_c;
        color_t     clr_c;
        color_t     exp_c;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fill(input color_t col);
        for (int i = 0; i < TILE_PIXELS; i++) begin
            X           = i[4:0];
            Y           = i[9:5];
            clearPixel  = 1'b1;
            clear_color = col;
            model[i]    = col;
            @(negedge clk);
        end
        clearPixel = 1'b0;
    endtask

    // Entered and left on a negedge. Every accepted beat is checked against the model.
    task automatic run_flush(input bit rand_ready, input int write_at, input int reflush_at,
                             input int reset_at, input bit co_wr, input logic [4:0] co_x,
                             input logic [4:0] co_y, input color_t co_col);
        int         idx = 0;
        int         cyc = 0;
        int         drops = 0;
        int         last_cyc = -1;
        bit         done = 0;
        bit         aborted = 0;
        bit         prev_stall = 0;
        bit         wrote = 0;
        bit         reflushed = 0;
        color_t     pd = '0;
        logic [4:0] px = '0;
        logic [4:0] py = '0;
        logic       pl = 1'b0;

        flush = 1'b1;
        if (co_wr) begin
            X = co_x; Y = co_y; tri_color = co_col; rasterPixel = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        rasterPixel = 1'b0;
        check("busy_rise", busy, 1);
`ifdef TILE_BUFFER_STATS_EN
        check("raster_count_cleared", raster_count, 0);
`endif
        while (!done && cyc < 20000) begin
            if (wr_drop) drops++;
            rasterPixel = 1'b0;
            flush = 1'b0;
            if (prev_stall)
                check("stall_hold", {out_valid, out_data, out_x, out_y, out_last},
                      {1'b1, pd, px, py, pl});
            if (reset_at >= 0 && idx == reset_at && out_valid) begin
                rst = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_valid", out_valid, 0);
                check("rst_outs", {out_data, out_x, out_y, out_last, wr_drop}, 0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1;
                done = 1;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid) begin
                    if (out_ready) begin
                        check($sformatf("beat%0d_data", idx), out_data, model[idx]);
                        check($sformatf("beat%0d_xy", idx), {out_y, out_x}, idx[9:0]);
                        check($sformatf("beat%0d_last", idx), out_last, idx == TILE_PIXELS - 1);
                        cap[idx] = out_data;
                        if (idx == TILE_PIXELS - 1) begin
                            done = 1;
                            last_cyc = cyc;
                        end
                        idx++;
                    end
                    if (!wrote && write_at >= 0 && idx >= write_at) begin
                        X = 5'd0; Y = 5'd0; tri_color = 16'hDEAD; rasterPixel = 1'b1;
                        wrote = 1;
                    end
                    if (!reflushed && reflush_at >= 0 && idx >= reflush_at) begin
                        flush = 1'b1;
                        reflushed = 1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data; px = out_x; py = out_y; pl = out_last;
                @(negedge clk);
                cyc++;
            end
        end
        if (!aborted) begin
            if (wr_drop) drops++;
            check("flush_done", done, 1);
            check("busy_fall", busy, 0);
            check("valid_fall", out_valid, 0);
            check("beat_count", idx, TILE_PIXELS);
            if (!rand_ready) check("flush_latency", last_cyc, 1024);
        end
        check("wr_drop_pulses", drops, (write_at >= 0) ? 1 : 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        X = '0; Y = '0; clearPixel = 1'b0; rasterPixel = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tri_color = '0; clear_color = '0;

        vecs[0] = '{x: 5'd3,  y: 5'd5,  r: 1'b1, c: 1'b1, tri_c: 16'hBEEF, clr_c: 16'h7777, exp_c: 16'hBEEF};
        vecs[1] = '{x: 5'd10, y: 5'd0,  r: 1'b0, c: 1'b1, tri_c: 16'hAAAA, clr_c: 16'h5A5A, exp_c: 16'h5A5A};
        vecs[2] = '{x: 5'd31, y: 5'd31, r: 1'b1, c: 1'b0, tri_c: 16'hCAFE, clr_c: 16'h1111, exp_c: 16'hCAFE};
        vecs[3] = '{x: 5'd0,  y: 5'd31, r: 1'b0, c: 1'b0, tri_c: 16'hFFFF, clr_c: 16'hFFFF, exp_c: 16'h0000};
        vecs[4] = '{x: 5'd31, y: 5'd0,  r: 1'b1, c: 1'b0, tri_c: 16'h0001, clr_c: 16'h0000, exp_c: 16'h0001};
        vecs[5] = '{x: 5'd17, y: 5'd12, r: 1'b0, c: 1'b1, tri_c: 16'hC0DE, clr_c: 16'h8001, exp_c: 16'h8001};

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_valid", out_valid, 0);
        check("reset_outs", {out_data, out_x, out_y, out_last, wr_drop}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);

        // Clear pass
        fill(16'h1234);
        run_flush(0, -1, -1, -1, 0, 5'd0, 5'd0, 16'h0);

        // Table writes over a zero background
        fill(16'h0000);
        for (int i = 0; i < 6; i++) begin
            X = vecs[i].x; Y = vecs[i].y;
            rasterPixel = vecs[i].r; clearPixel = vecs[i].c;
            tri_color = vecs[i].tri_c; clear_color = vecs[i].clr_c;
            model[pix_addr(vecs[i].x, vecs[i].y)] = vecs[i].exp_c;
            @(negedge clk);
        end
        rasterPixel = 1'b0; clearPixel = 1'b0;
        run_flush(0, -1, -1, -1, 0, 5'd0, 5'd0, 16'h0);
        for (int i = 0; i < 6; i++)
            check($sformatf("tbl%0d", i), cap[pix_addr(vecs[i].x, vecs[i].y)], vecs[i].exp_c);

        // Backpressure
        run_flush(1, -1, -1, -1, 0, 5'd0, 5'd0, 16'h0);

        // Write during flush is dropped; next flush still shows the old (0,0)
        run_flush(0, 10, -1, -1, 0, 5'd0, 5'd0, 16'h0);
        run_flush(0, -1, -1, -1, 0, 5'd0, 5'd0, 16'h0);
        check("old_pixel_00", cap[0], 16'h0000);

        // Second flush at beat 100 is ignored, reset at beat 500 abandons the stream
        run_flush(0, -1, 100, 500, 0, 5'd0, 5'd0, 16'h0);
        check("post_rst_busy", busy, 0);

        // Restart from (0,0) with a write in the same cycle as the flush
        model[pix_addr(5'd1, 5'd1)] = 16'h4242;
        run_flush(0, -1, -1, -1, 1, 5'd1, 5'd1, 16'h4242);
        check("co_write_seen", cap[pix_addr(5'd1, 5'd1)], 16'h4242);

`ifdef TILE_BUFFER_STATS_EN
        for (int i = 0; i < 37; i++) begin
            X = 5'(i % 32); Y = 5'(20 + i / 32);
            rasterPixel = 1'b1; tri_color = 16'h3700 + 16'(i);
            model[pix_addr(5'(i % 32), 5'(20 + i / 32))] = 16'h3700 + 16'(i);
            @(negedge clk);
        end
        rasterPixel = 1'b0;
        X = 5'd9; Y = 5'd9; clearPixel = 1'b1; clear_color = 16'h0909;
        model[pix_addr(5'd9, 5'd9)] = 16'h0909;
        @(negedge clk);
        clearPixel = 1'b0;
        check("raster_count_37", raster_count, 37);
        run_flush(0, -1, -1, -1, 0, 5'd0, 5'd0, 16'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
